// File: rtl/pal_video_timing_if.sv
// Raster timing bundle between the PAL timing generator and its downstream consumers.
// The consumer drives enable; the generator drives everything else.
interface pal_video_timing_if;
  logic       enable;
  logic [9:0] hPos;
  logic [9:0] vPos;
  logic       blank;
  logic       sync;
  logic       burst;
  logic       field;
  logic       lineStart;
  logic       fieldStart;

  modport master (
    input  enable,
    output hPos, vPos, blank, sync, burst, field, lineStart, fieldStart
  );

  modport slave (
    output enable,
    input  hPos, vPos, blank, sync, burst, field, lineStart, fieldStart
  );
endinterface

// File: rtl/pal_video_timing.sv
// PAL 625/50 interlaced raster timing generator at 13.5 MHz (BT.601 sampling).
// Counter state is decoded combinationally and registered, giving one cycle of output latency.
module pal_video_timing #(
  parameter logic [9:0] H_TOTAL        = 10'd864,
  parameter logic [9:0] H_ACTIVE       = 10'd720,
  parameter logic [9:0] H_ACTIVE_START = 10'd132,
  parameter logic [9:0] H_SYNC         = 10'd64,
  parameter logic [9:0] H_EQ           = 10'd32,
  parameter logic [9:0] H_BROAD        = 10'd368,
  parameter logic [9:0] H_BURST_START  = 10'd76,
  parameter logic [9:0] H_BURST_LEN    = 10'd30
) (
  input  logic                palClock,
  input  logic                reset,
  pal_video_timing_if.master  vt
);

  localparam logic [9:0] H_HALF      = H_TOTAL >> 1;
  localparam logic [9:0] H_BURST_END = H_BURST_START + H_BURST_LEN;
  localparam logic [9:0] LINES       = 10'd625;

  localparam logic [1:0] SYNC_N    = 2'd0;
  localparam logic [1:0] SYNC_E    = 2'd1;
  localparam logic [1:0] SYNC_B    = 2'd2;
  localparam logic [1:0] SYNC_NONE = 2'd3;

  // Sync type of each half-line as {first half, second half}.
  function automatic logic [3:0] line_type(input logic [9:0] ln);
    case (ln)
      10'd1, 10'd2, 10'd314, 10'd315:                          return {SYNC_B, SYNC_B};
      10'd3:                                                   return {SYNC_B, SYNC_E};
      10'd4, 10'd5, 10'd311, 10'd312, 10'd316, 10'd317,
      10'd624, 10'd625:                                        return {SYNC_E, SYNC_E};
      10'd313:                                                 return {SYNC_E, SYNC_B};
      10'd318:                                                 return {SYNC_E, SYNC_NONE};
      10'd623:                                                 return {SYNC_N, SYNC_E};
      default:                                                 return {SYNC_N, SYNC_NONE};
    endcase
  endfunction

  function automatic logic in_pulse(input logic [1:0] kind, input logic [9:0] off);
    case (kind)
      SYNC_N:  return off < H_SYNC;
      SYNC_E:  return off < H_EQ;
      SYNC_B:  return off < H_BROAD;
      default: return 1'b0;
    endcase
  endfunction

  logic [9:0] sample_p0;
  logic [9:0] line_p0;

  logic       second_half;
  logic [9:0] half_off;
  logic [3:0] lt;
  logic [1:0] kind;
  logic       active0;
  logic       active1;
  logic       burst_line;
  logic [9:0] hpos_d;
  logic [9:0] vpos_d;
  logic       blank_d;
  logic       sync_d;
  logic       burst_d;
  logic       field_d;
  logic       line_start_d;
  logic       field_start_d;

  // Stage p0 -> p1: decode the counter state
  always_comb begin
    second_half   = sample_p0 >= H_HALF;
    half_off      = second_half ? sample_p0 - H_HALF : sample_p0;
    lt            = line_type(line_p0);
    kind          = second_half ? lt[1:0] : lt[3:2];
    sync_d        = in_pulse(kind, half_off);

    hpos_d        = (sample_p0 < H_ACTIVE_START) ? sample_p0 + (H_TOTAL - H_ACTIVE_START)
                                                 : sample_p0 - H_ACTIVE_START;
    active0       = (line_p0 >= 10'd23)  && (line_p0 <= 10'd310);
    active1       = (line_p0 >= 10'd335) && (line_p0 <= 10'd622);

    // Interleave the two fields into frame order: field 0 even lines, field 1 odd lines.
    vpos_d        = '0;
    if (active0)
      vpos_d = (line_p0 - 10'd23) << 1;
    else if (active1)
      vpos_d = ((line_p0 - 10'd335) << 1) | 10'd1;

    blank_d       = !((active0 || active1) && (hpos_d < H_ACTIVE));
    burst_line    = ((line_p0 >= 10'd7)   && (line_p0 <= 10'd309)) ||
                    ((line_p0 >= 10'd320) && (line_p0 <= 10'd622));
    burst_d       = burst_line && (sample_p0 >= H_BURST_START) && (sample_p0 < H_BURST_END);
    field_d       = line_p0 >= 10'd313;
    line_start_d  = sample_p0 == '0;
    field_start_d = line_start_d && ((line_p0 == 10'd1) || (line_p0 == 10'd313));
  end

  // Stage p1: registered outputs and counter advance
  always_ff @(posedge palClock) begin
    if (reset || !vt.enable) begin
      sample_p0     <= '0;
      line_p0       <= 10'd1;
      vt.hPos       <= '0;
      vt.vPos       <= '0;
      vt.blank      <= 1'b1;
      vt.sync       <= 1'b0;
      vt.burst      <= 1'b0;
      vt.field      <= 1'b0;
      vt.lineStart  <= 1'b0;
      vt.fieldStart <= 1'b0;
    end else begin
      vt.hPos       <= hpos_d;
      vt.vPos       <= vpos_d;
      vt.blank      <= blank_d;
      vt.sync       <= sync_d;
      vt.burst      <= burst_d;
      vt.field      <= field_d;
      vt.lineStart  <= line_start_d;
      vt.fieldStart <= field_start_d;
      if (sample_p0 == H_TOTAL - 10'd1) begin
        sample_p0 <= '0;
        line_p0   <= (line_p0 == LINES) ? 10'd1 : line_p0 + 10'd1;
      end else begin
        sample_p0 <= sample_p0 + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_pal_video_timing.sv
// Bench for pal_video_timing: a raster-position model (frame time index -> line/sample ->
// outputs) scores every cycle, plus targeted checks of sync/burst/blank shapes per line.
module tb_pal_video_timing;
  logic palClock = 1'b0;
  logic reset;

  pal_video_timing_if vif();

  pal_video_timing dut (
    .palClock (palClock),
    .reset    (reset),
    .vt       (vif)
  );

  always #5 palClock = ~palClock;

  localparam int FRAME = 625 * 864;
  // {hPos[25:16], vPos[15:6], blank, sync, burst, field, lineStart, fieldStart}
  localparam logic [25:0] IDLE = 26'h20;

  int          errors = 0;
  int          checks = 0;
  int          t_mod  = 0;
  logic [25:0] exp_v;
  logic [25:0] obs_tr [864];
  logic [25:0] exp_tr [864];
  logic [9:0]  f_line;
  logic [9:0]  f_sample;

  // Reference: outputs for frame time index t, derived from line/sample arithmetic.
  function automatic logic [25:0] ref_out(input int t);
    int  ln, s, off, w, hp, vp;
    byte k0, k1, k;
    logic act, bl, sy, bu;
    ln  = t / 864 + 1;
    s   = t % 864;
    off = s % 432;
    k0 = "N"; k1 = "-";
    if (ln inside {1, 2, 314, 315})                        begin k0 = "B"; k1 = "B"; end
    else if (ln == 3)                                      begin k0 = "B"; k1 = "E"; end
    else if (ln inside {4, 5, 311, 312, 316, 317, 624, 625}) begin k0 = "E"; k1 = "E"; end
    else if (ln == 313)                                    begin k0 = "E"; k1 = "B"; end
    else if (ln == 318)                                    begin k0 = "E"; k1 = "-"; end
    else if (ln == 623)                                    begin k0 = "N"; k1 = "E"; end
    k = (s < 432) ? k0 : k1;
    case (k)
      "N":     w = 64;
      "E":     w = 32;
      "B":     w = 368;
      default: w = 0;
    endcase
    sy  = off < w;
    hp  = (s + 864 - 132) % 864;
    vp  = 0;
    if (ln >= 23 && ln <= 310)       vp = 2 * (ln - 23);
    else if (ln >= 335 && ln <= 622) vp = 2 * (ln - 335) + 1;
    act = (ln >= 23 && ln <= 310) || (ln >= 335 && ln <= 622);
    bl  = !(act && hp < 720);
    bu  = (s >= 76) && (s < 106) && ((ln >= 7 && ln <= 309) || (ln >= 320 && ln <= 622));
    return {10'(hp), 10'(vp), bl, sy, bu, (ln >= 313), (s == 0), (s == 0) && (ln == 1 || ln == 313)};
  endfunction

  function automatic logic [25:0] obs_v();
    return {vif.hPos, vif.vPos, vif.blank, vif.sync, vif.burst, vif.field,
            vif.lineStart, vif.fieldStart};
  endfunction

  // Run lengths of one output bit across the captured line, e.g. "368 64 368 64".
  function automatic string run_str(input int bitn);
    string s = "";
    int    r = 1;
    for (int i = 1; i < 864; i++) begin
      if (obs_tr[i][bitn] == obs_tr[i-1][bitn]) r++;
      else begin
        s = {s, $sformatf("%0d ", r)};
        r = 1;
      end
    end
    s = {s, $sformatf("%0d", r)};
    return s;
  endfunction

  task automatic step();
    if (reset || !vif.enable) begin
      exp_v = IDLE;
      t_mod = 0;
    end else begin
      exp_v = ref_out(t_mod);
      t_mod = (t_mod + 1) % FRAME;
    end
    @(posedge palClock);
    #1;
  endtask

  task automatic capture_line();
    for (int i = 0; i < 864; i++) begin
      step();
      obs_tr[i] = obs_v();
      exp_tr[i] = exp_v;
    end
  endtask

  // Move the raster to an arbitrary position so distant lines are reachable quickly.
  task automatic jump_to(input int ln, input int s);
    f_line   = 10'(ln);
    f_sample = 10'(s);
    force dut.line_p0   = f_line;
    force dut.sample_p0 = f_sample;
    release dut.line_p0;
    release dut.sample_p0;
    t_mod = (ln - 1) * 864 + s;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vif.enable = (i == 2);
      step();
      checks++;
      if (obs_v() !== IDLE) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %h want %h", i, obs_v(), IDLE);
      end
    end
  endtask

  task automatic test_line1();
    string got;
    reset = 1'b0;
    vif.enable = 1'b1;
    capture_line();
    for (int i = 0; i < 864; i++) begin
      checks++;
      if (obs_tr[i] !== exp_tr[i]) begin
        errors++;
        $display("FAIL line1_model s %0d: got %h want %h", i, obs_tr[i], exp_tr[i]);
      end
    end
    checks++;
    if (obs_tr[0][5:0] !== 6'b110011) begin
      errors++;
      $display("FAIL line1_first_flags: got %b want 110011", obs_tr[0][5:0]);
    end
    got = run_str(4);
    checks++;
    if (got != "368 64 368 64") begin
      errors++;
      $display("FAIL line1_sync_runs: got %s want 368 64 368 64", got);
    end
    got = run_str(1);
    checks++;
    if (got != "1 863") begin
      errors++;
      $display("FAIL line1_linestart_runs: got %s want 1 863", got);
    end
  endtask

  task automatic test_line23();
    string got;
    jump_to(23, 0);
    capture_line();
    for (int i = 0; i < 864; i++) begin
      checks++;
      if (obs_tr[i] !== exp_tr[i]) begin
        errors++;
        $display("FAIL line23_model s %0d: got %h want %h", i, obs_tr[i], exp_tr[i]);
      end
    end
    got = run_str(3);
    checks++;
    if (got != "76 30 758") begin
      errors++;
      $display("FAIL line23_burst_runs: got %s want 76 30 758", got);
    end
    got = run_str(5);
    checks++;
    if (got != "132 720 12") begin
      errors++;
      $display("FAIL line23_blank_runs: got %s want 132 720 12", got);
    end
    checks++;
    if (obs_tr[132][25:16] !== 10'd0 || obs_tr[132][15:6] !== 10'd0) begin
      errors++;
      $display("FAIL line23_blank_fall_pos: got h=%0d v=%0d want h=0 v=0",
               obs_tr[132][25:16], obs_tr[132][15:6]);
    end
    checks++;
    if (obs_tr[852][25:16] !== 10'd720) begin
      errors++;
      $display("FAIL line23_blank_rise_hpos: got %0d want 720", obs_tr[852][25:16]);
    end
  endtask

  task automatic test_field1();
    string got;
    int    want_v [3] = '{1, 3, 575};
    int    lines  [3] = '{335, 336, 622};
    for (int k = 0; k < 3; k++) begin
      if (k != 1) jump_to(lines[k], 0);
      capture_line();
      for (int i = 0; i < 864; i++) begin
        checks++;
        if (obs_tr[i] !== exp_tr[i]) begin
          errors++;
          $display("FAIL line%0d_model s %0d: got %h want %h", lines[k], i, obs_tr[i], exp_tr[i]);
        end
      end
      checks++;
      if (obs_tr[132][15:6] !== 10'(want_v[k]) || obs_tr[132][5] !== 1'b0) begin
        errors++;
        $display("FAIL line%0d_vpos: got v=%0d blank=%b want v=%0d blank=0",
                 lines[k], obs_tr[132][15:6], obs_tr[132][5], want_v[k]);
      end
    end
    capture_line();
    for (int i = 0; i < 864; i++) begin
      checks++;
      if (obs_tr[i] !== exp_tr[i]) begin
        errors++;
        $display("FAIL line623_model s %0d: got %h want %h", i, obs_tr[i], exp_tr[i]);
      end
    end
    got = run_str(5);
    checks++;
    if (got != "864" || obs_tr[0][5] !== 1'b1) begin
      errors++;
      $display("FAIL line623_blank: got runs %s first %b want 864 first 1", got, obs_tr[0][5]);
    end
    got = run_str(4);
    checks++;
    if (got != "64 368 32 400") begin
      errors++;
      $display("FAIL line623_sync_runs: got %s want 64 368 32 400", got);
    end
  endtask

  task automatic test_field_wrap();
    string got;
    jump_to(312, 0);
    capture_line();
    checks++;
    if (obs_tr[863][2] !== 1'b0) begin
      errors++;
      $display("FAIL line312_field: got %b want 0", obs_tr[863][2]);
    end
    capture_line();
    for (int i = 0; i < 864; i++) begin
      checks++;
      if (obs_tr[i] !== exp_tr[i]) begin
        errors++;
        $display("FAIL line313_model s %0d: got %h want %h", i, obs_tr[i], exp_tr[i]);
      end
    end
    checks++;
    if (obs_tr[0][2] !== 1'b1 || obs_tr[0][0] !== 1'b1) begin
      errors++;
      $display("FAIL line313_field_start: got field=%b fs=%b want 1 1", obs_tr[0][2], obs_tr[0][0]);
    end
    got = run_str(4);
    checks++;
    if (got != "32 400 368 64") begin
      errors++;
      $display("FAIL line313_sync_runs: got %s want 32 400 368 64", got);
    end
    jump_to(625, 860);
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (obs_v() !== exp_v) begin
        errors++;
        $display("FAIL frame_wrap_model cyc %0d: got %h want %h", i, obs_v(), exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    jump_to(100, 497);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs_v() !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_pre cyc %0d: got %h want %h", i, obs_v(), exp_v);
      end
    end
    reset = 1'b1;
    step();
    checks++;
    if (obs_v() !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_idle: got %h want %h", obs_v(), IDLE);
    end
    reset = 1'b0;
    step();
    checks++;
    if (vif.sync !== 1'b1 || vif.fieldStart !== 1'b1 || vif.field !== 1'b0 || vif.hPos !== 10'd732) begin
      errors++;
      $display("FAIL reset_mid_restart: got sync=%b fs=%b field=%b h=%0d want 1 1 0 732",
               vif.sync, vif.fieldStart, vif.field, vif.hPos);
    end
  endtask

  task automatic test_enable_drop();
    jump_to(400, 37);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs_v() !== exp_v) begin
        errors++;
        $display("FAIL endrop_pre cyc %0d: got %h want %h", i, obs_v(), exp_v);
      end
    end
    vif.enable = 1'b0;
    step();
    checks++;
    if (obs_v() !== IDLE) begin
      errors++;
      $display("FAIL endrop_idle: got %h want %h", obs_v(), IDLE);
    end
    vif.enable = 1'b1;
    step();
    checks++;
    if (vif.fieldStart !== 1'b1 || vif.lineStart !== 1'b1 || vif.sync !== 1'b1) begin
      errors++;
      $display("FAIL endrop_restart: got fs=%b ls=%b sync=%b want 1 1 1",
               vif.fieldStart, vif.lineStart, vif.sync);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs_v() !== exp_v) begin
        errors++;
        $display("FAIL endrop_post cyc %0d: got %h want %h", i, obs_v(), exp_v);
      end
    end
  endtask

  task automatic test_random();
    int hot [8] = '{3, 6, 22, 310, 312, 318, 334, 624};
    for (int n = 0; n < 20000; n++) begin
      if (n % 1000 == 0) begin
        if ($urandom_range(0, 1) == 0) jump_to(hot[$urandom_range(0, 7)], $urandom_range(0, 863));
        else jump_to($urandom_range(1, 625), $urandom_range(0, 863));
      end
      reset      = ($urandom_range(0, 2999) == 0);
      vif.enable = ($urandom_range(0, 499) != 0);
      step();
      checks++;
      if (obs_v() !== exp_v) begin
        errors++;
        $display("FAIL random cyc %0d: got %h want %h", n, obs_v(), exp_v);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    vif.enable = 1'b0;
    test_reset();
    test_line1();
    test_line23();
    test_field1();
    test_field_wrap();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
